// File: rtl/tdm_demux_1to4_pkg.sv
// Shared constants for the 1-to-4 TDM demultiplexer: FSM encoding and slot geometry.
package tdm_demux_1to4_pkg;

  localparam logic STATE_HUNT   = 1'b0;
  localparam logic STATE_LOCKED = 1'b1;

  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W    = 2;

  localparam logic [SLOT_W-1:0] SLOT_FIRST = 2'd0;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = 2'd3;

endpackage

// File: rtl/tdm_demux_1to4_lane_reg.sv
// Load-enabled WIDTH-bit lane register with asynchronous active-low clear.
module lane_reg #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] val_q;
  logic [WIDTH-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (load) val_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) val_q <= '0;
    else        val_q <= val_d;
  end

  assign q = val_q;

endmodule

// File: rtl/tdm_demux_1to4.sv
// 1-to-4 TDM demultiplexer: hunts for frame_sync, then steers each valid word to its slot lane.
// Handshake: din_valid qualifies din and frame_sync for one cycle; there is no backpressure.
module tdm_demux_1to4
  import tdm_demux_1to4_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  input  logic             frame_sync,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [3:0]       y_valid,
  output logic [1:0]       slot,
  output logic             locked,
  output logic             frame_done,
  output logic             sync_err
);

  logic              state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [3:0]        y_valid_q, y_valid_d;
  logic              frame_done_q, frame_done_d;
  logic              sync_err_q, sync_err_d;
  logic [3:0]        load;
  logic [WIDTH-1:0]  lane_q [NUM_SLOTS];

  always_comb begin
    state_d      = state_q;
    slot_d       = slot_q;
    load         = 4'b0000;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      if (state_q == STATE_HUNT) begin
        if (frame_sync) begin
          load[0] = 1'b1;
          slot_d  = 2'd1;
          state_d = STATE_LOCKED;
        end
      end else if (frame_sync) begin
        // A sync anywhere but slot 0 realigns the frame onto this word.
        load[0]    = 1'b1;
        slot_d     = 2'd1;
        sync_err_d = (slot_q != SLOT_FIRST);
      end else if (slot_q == SLOT_FIRST) begin
        sync_err_d = 1'b1;
        slot_d     = SLOT_FIRST;
        state_d    = STATE_HUNT;
      end else begin
        load[slot_q] = 1'b1;
        slot_d       = slot_q + 2'd1;
        frame_done_d = (slot_q == SLOT_LAST);
      end
    end
    y_valid_d = load;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= STATE_HUNT;
      slot_q       <= SLOT_FIRST;
      y_valid_q    <= 4'b0000;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      y_valid_q    <= y_valid_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
    end
  end

  for (genvar i = 0; i < NUM_SLOTS; i++) begin : g_lane
    lane_reg #(.WIDTH(WIDTH)) u_lane (
      .clk  (clk),
      .rst_n(rst_n),
      .load (load[i]),
      .d    (din),
      .q    (lane_q[i])
    );
  end

  assign y0         = lane_q[0];
  assign y1         = lane_q[1];
  assign y2         = lane_q[2];
  assign y3         = lane_q[3];
  assign y_valid    = y_valid_q;
  assign slot       = slot_q;
  assign locked     = (state_q == STATE_LOCKED);
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Directed bench for tdm_demux_1to4 at WIDTH=8 with hand-computed expected outputs.
module tb_tdm_demux_1to4;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] din;
  logic         din_valid;
  logic         frame_sync;
  logic [W-1:0] y0, y1, y2, y3;
  logic [3:0]   y_valid;
  logic [1:0]   slot;
  logic         locked;
  logic         frame_done;
  logic         sync_err;

  int total = 0;
  int bad   = 0;

  tdm_demux_1to4 #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .din_valid (din_valid),
    .frame_sync(frame_sync),
    .y0        (y0),
    .y1        (y1),
    .y2        (y2),
    .y3        (y3),
    .y_valid   (y_valid),
    .slot      (slot),
    .locked    (locked),
    .frame_done(frame_done),
    .sync_err  (sync_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [W-1:0] e0, input logic [W-1:0] e1,
                         input logic [W-1:0] e2, input logic [W-1:0] e3,
                         input logic [3:0] e_yv, input logic [1:0] e_slot,
                         input logic e_lk, input logic e_fd, input logic e_se);
    chk({tag, ".y0"}, 32'(y0), 32'(e0));
    chk({tag, ".y1"}, 32'(y1), 32'(e1));
    chk({tag, ".y2"}, 32'(y2), 32'(e2));
    chk({tag, ".y3"}, 32'(y3), 32'(e3));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(e_yv));
    chk({tag, ".slot"}, 32'(slot), 32'(e_slot));
    chk({tag, ".locked"}, 32'(locked), 32'(e_lk));
    chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_fd));
    chk({tag, ".sync_err"}, 32'(sync_err), 32'(e_se));
    chk({tag, ".onehot"}, 32'($countones(y_valid) <= 1), 32'd1);
  endtask

  // driver tasks: inputs change on the falling edge, outputs sampled 1ns after the rising edge
  task automatic send(input logic [W-1:0] d, input logic s);
    @(negedge clk);
    din        = d;
    din_valid  = 1'b1;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic s);
    @(negedge clk);
    din        = $urandom_range(0, 255);
    din_valid  = 1'b0;
    frame_sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("rst_hold", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    din        = '0;
    din_valid  = 1'b0;
    frame_sync = 1'b0;
    do_reset();

    // basic frame
    send(8'hA0, 1'b1); chk_all("b0", 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 2'd1, 1, 0, 0);
    send(8'hB1, 1'b0); chk_all("b1", 8'hA0, 8'hB1, 8'h00, 8'h00, 4'b0010, 2'd2, 1, 0, 0);
    send(8'hC2, 1'b0); chk_all("b2", 8'hA0, 8'hB1, 8'hC2, 8'h00, 4'b0100, 2'd3, 1, 0, 0);
    send(8'hD3, 1'b0); chk_all("b3", 8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1000, 2'd0, 1, 1, 0);

    // gaps between words, including a sync with din_valid low
    do_reset();
    send(8'hA0, 1'b1); chk_all("g0", 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0001, 2'd1, 1, 0, 0);
    idle(1'b0);        chk_all("g0i", 8'hA0, 8'h00, 8'h00, 8'h00, 4'b0000, 2'd1, 1, 0, 0);
    send(8'hB1, 1'b0); chk_all("g1", 8'hA0, 8'hB1, 8'h00, 8'h00, 4'b0010, 2'd2, 1, 0, 0);
    idle(1'b1);        chk_all("g1i", 8'hA0, 8'hB1, 8'h00, 8'h00, 4'b0000, 2'd2, 1, 0, 0);
    send(8'hC2, 1'b0); chk_all("g2", 8'hA0, 8'hB1, 8'hC2, 8'h00, 4'b0100, 2'd3, 1, 0, 0);
    idle(1'b0);        chk_all("g2i", 8'hA0, 8'hB1, 8'hC2, 8'h00, 4'b0000, 2'd3, 1, 0, 0);
    send(8'hD3, 1'b0); chk_all("g3", 8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1000, 2'd0, 1, 1, 0);
    idle(1'b0);        chk_all("g3i", 8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b0000, 2'd0, 1, 0, 0);

    // early sync at slot 2 realigns
    send(8'h11, 1'b1); chk_all("e0", 8'h11, 8'hB1, 8'hC2, 8'hD3, 4'b0001, 2'd1, 1, 0, 0);
    send(8'h22, 1'b0); chk_all("e1", 8'h11, 8'h22, 8'hC2, 8'hD3, 4'b0010, 2'd2, 1, 0, 0);
    send(8'h55, 1'b1); chk_all("e_sync", 8'h55, 8'h22, 8'hC2, 8'hD3, 4'b0001, 2'd1, 1, 0, 1);
    send(8'h66, 1'b0); chk_all("e2", 8'h55, 8'h66, 8'hC2, 8'hD3, 4'b0010, 2'd2, 1, 0, 0);
    send(8'h77, 1'b0); chk_all("e3", 8'h55, 8'h66, 8'h77, 8'hD3, 4'b0100, 2'd3, 1, 0, 0);
    send(8'h88, 1'b0); chk_all("e4", 8'h55, 8'h66, 8'h77, 8'h88, 4'b1000, 2'd0, 1, 1, 0);

    // missing sync at slot 0 drops to HUNT
    send(8'h99, 1'b0); chk_all("m_err", 8'h55, 8'h66, 8'h77, 8'h88, 4'b0000, 2'd0, 0, 0, 1);
    send(8'h9A, 1'b0); chk_all("m_ign", 8'h55, 8'h66, 8'h77, 8'h88, 4'b0000, 2'd0, 0, 0, 0);
    idle(1'b1);        chk_all("m_idle", 8'h55, 8'h66, 8'h77, 8'h88, 4'b0000, 2'd0, 0, 0, 0);

    // back-to-back frames across the 3->0 wrap
    send(8'hA0, 1'b1); chk_all("f0", 8'hA0, 8'h66, 8'h77, 8'h88, 4'b0001, 2'd1, 1, 0, 0);
    send(8'hB1, 1'b0); chk_all("f1", 8'hA0, 8'hB1, 8'h77, 8'h88, 4'b0010, 2'd2, 1, 0, 0);
    send(8'hC2, 1'b0); chk_all("f2", 8'hA0, 8'hB1, 8'hC2, 8'h88, 4'b0100, 2'd3, 1, 0, 0);
    send(8'hD3, 1'b0); chk_all("f3", 8'hA0, 8'hB1, 8'hC2, 8'hD3, 4'b1000, 2'd0, 1, 1, 0);
    send(8'h10, 1'b1); chk_all("f4", 8'h10, 8'hB1, 8'hC2, 8'hD3, 4'b0001, 2'd1, 1, 0, 0);
    send(8'h11, 1'b0); chk_all("f5", 8'h10, 8'h11, 8'hC2, 8'hD3, 4'b0010, 2'd2, 1, 0, 0);
    send(8'h12, 1'b0); chk_all("f6", 8'h10, 8'h11, 8'h12, 8'hD3, 4'b0100, 2'd3, 1, 0, 0);
    send(8'h13, 1'b0); chk_all("f7", 8'h10, 8'h11, 8'h12, 8'h13, 4'b1000, 2'd0, 1, 1, 0);

    // mid-frame asynchronous reset
    send(8'h20, 1'b1); chk_all("r0", 8'h20, 8'h11, 8'h12, 8'h13, 4'b0001, 2'd1, 1, 0, 0);
    send(8'h21, 1'b0); chk_all("r1", 8'h20, 8'h21, 8'h12, 8'h13, 4'b0010, 2'd2, 1, 0, 0);
    @(negedge clk);
    rst_n     = 1'b0;
    din_valid = 1'b0;
    #1;
    chk_all("r_async", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h30, 1'b0); chk_all("r_ign", 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 2'd0, 0, 0, 0);
    send(8'h31, 1'b1); chk_all("r_sync", 8'h31, 8'h00, 8'h00, 8'h00, 4'b0001, 2'd1, 1, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdm_demux_1to4.md
TDM_DEMUX_1TO4 -- requirements
Module: tdm_demux_1to4

Interface
REQ-001 Parameter: WIDTH, default 1, sets the data width of din and of each output lane.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 Port: din  input  WIDTH  time-multiplexed data word for the current slot.
REQ-005 Port: din_valid  input  1  din carries a slot word this cycle.
REQ-006 Port: frame_sync  input  1  qualified by din_valid; marks the slot-0 word of a frame.
REQ-007 Port: y0, y1, y2, y3  output  WIDTH each  registered lane outputs; each holds its last captured word.
REQ-008 Port: y_valid  output  4  one-cycle strobe per lane; bit n pulses when yn updates.
REQ-009 Port: slot  output  2  index of the next expected slot, in {s1,s0} order (slot 0 = lane 0).
REQ-010 Port: locked  output  1  high while state is LOCKED.
REQ-011 Port: frame_done  output  1  one-cycle pulse when a slot-3 word is captured in LOCKED.
REQ-012 Port: sync_err  output  1  one-cycle pulse on a framing violation.

Function
REQ-013 The block SHALL use a two-state FSM: HUNT and LOCKED.
REQ-014 The block SHALL ignore din in HUNT unless din_valid=1 and frame_sync=1 in the same cycle.
- On that cycle: capture din into y0, pulse y_valid[0], set slot=1, enter LOCKED.
REQ-015 In LOCKED, with din_valid=1 and frame_sync=0 and slot!=0, the block SHALL:
- capture din into y[slot];
- pulse y_valid[slot];
- increment slot modulo 4 (3 wraps to 0).
REQ-016 In LOCKED, with din_valid=1, frame_sync=1 and slot=0, the block SHALL capture din into y0, pulse y_valid[0] and set slot=1.
REQ-017 In LOCKED, frame_sync=1 with din_valid=1 at slot!=0 (early sync) SHALL:
- pulse sync_err;
- capture din into y0 and pulse y_valid[0];
- set slot=1 and stay LOCKED (realign).
REQ-018 In LOCKED, din_valid=1 with frame_sync=0 at slot=0 (missing sync) SHALL:
- pulse sync_err;
- discard din, with no lane update;
- go to HUNT with slot=0.
REQ-019 din_valid=0 SHALL leave all lanes, slot and state unchanged, and all strobes low.
REQ-020 frame_sync with din_valid=0 SHALL be ignored.
REQ-021 Capture latency SHALL be one cycle: y_valid and the lane value appear on the edge after the accepted input.
REQ-022 At most one y_valid bit SHALL be high in any cycle.
REQ-023 frame_done SHALL pulse in the same cycle as y_valid[3].

Reset
REQ-024 While rst_n=0, the block SHALL hold:
- state=HUNT, slot=0, locked=0;
- y0..y3 all zero;
- y_valid=0, frame_done=0, sync_err=0.
REQ-025 Reset asserted mid-frame SHALL abandon the frame; after release, a fresh frame_sync is required.

Structure
REQ-026 A shared package SHALL hold the FSM state encoding (HUNT=0, LOCKED=1) and the slot-count constant 4.
REQ-027 One sub-module, lane_reg, SHALL implement a WIDTH-bit load-enabled register with async active-low clear, instanced four times.

Verification
REQ-028 The bench SHALL cover these directed scenarios:
- Basic frame: WIDTH=8, reset, then words A0,B1,C2,D3 on consecutive valid cycles with sync on A0 -> y0..y3=A0,B1,C2,D3; y_valid=0001,0010,0100,1000; frame_done with the last; locked=1.
- Gaps: the same frame with din_valid=0 cycles between words -> identical lane values; slot holds during gaps; no strobes in gap cycles.
- Early sync: sync on the third word (slot 2), value 55 -> sync_err pulse; y0=55; slot=1; locked stays 1.
- Missing sync: a fourth-plus-one word at slot 0 without sync -> sync_err pulse; lanes unchanged; locked=0; later words ignored until sync.
- Back-to-back frames: two frames, second value set 10..13 with sync -> wrap 3->0 is clean; two frame_done pulses; no sync_err.
- Mid-frame reset: rst_n low after 2 words -> all outputs zero immediately (asynchronous); after release, non-sync words are ignored.
